router_output_ctrl: RTL and testbench

ROUTER_OUTPUT_CTRL -- requirements
Module: router_output_ctrl

---
 rtl/router_output_ctrl.sv | 136 +++++++++++++
 tb/tb_router_output_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/router_output_ctrl.sv
// Output-port controller for a wormhole router: arbitrates head flits, then holds the port for the packet owner.
// Latency: zero -- grant is combinational from the current requests and registered state.
// Backpressure: credit based; no grant while the downstream credit pool is empty, returned credits usable next cycle.
module router_output_ctrl #(
  parameter int NUM_IN  = 5,
  parameter int CREDITS = 4,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] flit_valid,
  input  logic [NUM_IN-1:0] flit_head,
  input  logic [NUM_IN-1:0] flit_tail,
  input  logic              credit_return,
  output logic [NUM_IN-1:0] grant,
  output logic              out_valid,
  output logic [SEL_W-1:0]  out_sel,
  output logic              locked,
  output logic [3:0]        credit_cnt
);

  // IDLE: port free for a new packet; LOCKED: port owned by r_owner until its tail
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  logic [SEL_W-1:0]  r_owner;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic [3:0]        r_credit;

  logic [NUM_IN-1:0] w_elig;
  logic [SEL_W-1:0]  w_probe;
  logic              w_win_found;
  logic [SEL_W-1:0]  w_win_idx;
  logic              w_req;
  logic [SEL_W-1:0]  w_sel;
  logic              w_fire;
  logic [4:0]        w_credit_sum;
  logic [3:0]        w_credit_nxt;

  // (base + k) mod NUM_IN, with k < NUM_IN so one conditional subtract suffices
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return SEL_W'(s);
  endfunction

  // Round-robin search over head requests, starting at r_rr_ptr and wrapping upward
  always_comb begin
    w_elig      = flit_valid & flit_head;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_probe     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_probe = wrap_idx(r_rr_ptr, k);
      if (!w_win_found && w_elig[w_probe]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_probe;
      end
    end
  end

  // Pick the candidate: the owner while locked (head bit ignored), else the arbitration winner.
  // Reset gates the grant so nothing leaves the port while rst is low.
  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_req = flit_valid[r_owner];
      w_sel = r_owner;
    end else begin
      w_req = w_win_found;
      w_sel = w_win_idx;
    end
    w_fire    = rst && w_req && (r_credit != 4'd0);
    grant     = w_fire ? (NUM_IN'(1) << w_sel) : '0;
    out_valid = w_fire;
    out_sel   = w_fire ? w_sel : '0;
  end

  // Credit pool: -1 per forwarded flit, +1 per returned credit, clamped to the pool size
  always_comb begin
    w_credit_sum = {1'b0, r_credit} - {4'b0, w_fire} + {4'b0, credit_return};
    if (w_credit_sum > 5'(CREDITS)) begin
      w_credit_nxt = 4'(CREDITS);
    end else begin
      w_credit_nxt = w_credit_sum[3:0];
    end
  end

  // Packet-ownership FSM, round-robin pointer and credit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_credit <= 4'(CREDITS);
    end else begin
      r_credit <= w_credit_nxt;
      if (w_fire) begin
        case (r_state)
          ST_IDLE: begin
            // every IDLE grant is a head flit: advance the pointer past the winner
            r_rr_ptr <= wrap_idx(w_sel, 1);
            if (!flit_tail[w_sel]) begin
              r_state <= ST_LOCKED;
              r_owner <= w_sel;
            end
          end
          ST_LOCKED: begin
            // a head bit from the owner here is treated as body; only the tail releases
            if (flit_tail[w_sel]) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign locked     = (r_state == ST_LOCKED);
  assign credit_cnt = r_credit;

`ifndef SYNTHESIS
  // Structural invariants of the output port
  always @(posedge clk) begin
    if (rst) begin
      a_grant_onehot0 : assert ($onehot0(grant));
      a_credit_bound  : assert (credit_cnt <= 4'(CREDITS));
      a_no_credit     : assert (!(credit_cnt == 4'd0 && out_valid));
      a_lock_owner    : assert (!(locked && out_valid && out_sel != r_owner));
    end
  end
`endif

endmodule

// File: tb/tb_router_output_ctrl.sv
module tb_router_output_ctrl;
  localparam int NUM_IN  = 5;
  localparam int CREDITS = 4;

  logic       clk;
  logic       rst;
  logic [4:0] flit_valid;
  logic [4:0] flit_head;
  logic [4:0] flit_tail;
  logic       credit_return;
  logic [4:0] grant;
  logic       out_valid;
  logic [2:0] out_sel;
  logic       locked;
  logic [3:0] credit_cnt;

  router_output_ctrl #(.NUM_IN(NUM_IN), .CREDITS(CREDITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_valid   (flit_valid),
    .flit_head    (flit_head),
    .flit_tail    (flit_tail),
    .credit_return(credit_return),
    .grant        (grant),
    .out_valid    (out_valid),
    .out_sel      (out_sel),
    .locked       (locked),
    .credit_cnt   (credit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] g;
    logic [2:0] sel;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every forwarded flit must match the oldest expected grant, in the expected cycle
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (out_valid !== (|grant)) begin
      errors++;
      $display("FAIL out_valid_vs_grant cyc=%0d out_valid=%b grant=%b", cyc, out_valid, grant);
    end
    if (out_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flit cyc=%0d grant=%b out_sel=%0d expected none", cyc, grant, out_sel);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || e.g !== grant || e.sel !== out_sel) begin
          errors++;
          $display("FAIL grant_match cyc=%0d grant=%b sel=%0d required cyc=%0d grant=%b sel=%0d",
                   cyc, grant, out_sel, e.cyc, e.g, e.sel);
        end
      end
    end else begin
      checks++;
      if (grant !== 5'b0 || out_sel !== 3'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d grant=%b out_sel=%0d required 0/0", cyc, grant, out_sel);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, exp);
    end
  endtask

  // One cycle of stimulus; eg/es is the expected grant this cycle, el/ec the registered lock/credit seen in it
  task automatic step(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t, input logic cr,
                      input logic [4:0] eg, input logic [2:0] es, input logic el, input logic [3:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    flit_valid    = v;
    flit_head     = h;
    flit_tail     = t;
    credit_return = cr;
    if (eg != 5'b0) begin
      e.cyc = cyc;
      e.g   = eg;
      e.sel = es;
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("locked", 32'(locked), 32'(el));
    chk("credit_cnt", 32'(credit_cnt), 32'(ec));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with every input requesting: nothing may be granted
    rst           = 1'b0;
    flit_valid    = 5'b11111;
    flit_head     = 5'b11111;
    flit_tail     = 5'b00000;
    credit_return = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sel", 32'(out_sel), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_credit", 32'(credit_cnt), 32'd4);
    end
    @(posedge clk);
    #1;
    rst        = 1'b1;
    flit_valid = 5'b0;
    flit_head  = 5'b0;

    // round robin from rr_ptr=0, single-flit packets on inputs 2 and 4
    step(5'b10100, 5'b10100, 5'b10100, 1'b0, 5'b00100, 3'd2, 1'b0, 4'd4);
    step(5'b10100, 5'b10100, 5'b10100, 1'b0, 5'b10000, 3'd4, 1'b0, 4'd3);
    step(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 4'd2);
    step(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 4'd3);

    // input 1 sends a 4-flit packet while input 3 waits with a head; owner head bit mid-packet is body
    step(5'b01010, 5'b01010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b0, 4'd4);
    step(5'b01010, 5'b01000, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 4'd3);
    step(5'b01010, 5'b01010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 4'd3);
    step(5'b01010, 5'b01000, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b1, 4'd3);
    step(5'b01000, 5'b01000, 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b0, 4'd3);

    // rr_ptr=4: single-flit on input 4 wins over input 0, then pointer wraps to 0
    step(5'b10001, 5'b10001, 5'b10001, 1'b1, 5'b10000, 3'd4, 1'b0, 4'd3);
    step(5'b10001, 5'b10001, 5'b10001, 1'b1, 5'b00001, 3'd0, 1'b0, 4'd3);

    // credit return and forward in the same cycle at credit 2; return at full pool saturates
    step(5'b00100, 5'b00100, 5'b00100, 1'b0, 5'b00100, 3'd2, 1'b0, 4'd3);
    step(5'b00100, 5'b00100, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b0, 4'd2);
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 4'd2);
    step(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 4'd2);
    step(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 4'd3);
    step(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 4'd4);
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 4'd4);

    // 6-flit packet on input 0 with no returns: 4 flits, stall, one credit -> one flit the cycle after
    step(5'b00001, 5'b00001, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b0, 4'd4);
    step(5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 4'd3);
    step(5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 4'd2);
    step(5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 4'd1);
    step(5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b1, 4'd0);
    step(5'b00001, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b1, 4'd0);
    step(5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00001, 3'd0, 1'b1, 4'd1);
    step(5'b00001, 5'b00000, 5'b00001, 1'b0, 5'b00000, 3'd0, 1'b1, 4'd0);
    step(5'b00001, 5'b00000, 5'b00001, 1'b1, 5'b00000, 3'd0, 1'b1, 4'd0);

    // reset mid-packet while locked with one credit: effect is immediate
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_credit", 32'(credit_cnt), 32'd4);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    flit_valid    = 5'b0;
    flit_head     = 5'b0;
    flit_tail     = 5'b0;
    credit_return = 1'b0;

    // arbitration restarts from rr_ptr=0
    step(5'b00011, 5'b00011, 5'b00011, 1'b0, 5'b00001, 3'd0, 1'b0, 4'd4);
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 4'd3);
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 4'd3);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
